// File: rtl/signed_div32_seq.sv
// Sequential 32-bit signed divider with MIPS DIV semantics.
// It runs one restoring shift-subtract step per cycle over 32 cycles, then applies the result signs.
module signed_div32_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dvs;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_busy;
  logic        r_done;
  logic        r_div_zero;
  logic [31:0] r_quotient;
  logic [31:0] r_remainder;

  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_shift;
  logic        w_fits;
  logic [31:0] w_diff;

  // 0x80000000 maps to unsigned 2^31, which still fits the 32-bit magnitude.
  assign w_abs_a = dividend[31] ? (~dividend + 32'd1) : dividend;
  assign w_abs_b = divisor[31]  ? (~divisor  + 32'd1) : divisor;

  // The shifted partial remainder needs 33 bits; after subtraction it is always below the divisor.
  assign w_shift = {r_rem, r_quo[31]};
  assign w_fits  = (w_shift >= {1'b0, r_dvs});
  assign w_diff  = w_shift[31:0] - r_dvs;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= 6'd0;
      r_rem       <= 32'd0;
      r_quo       <= 32'd0;
      r_dvs       <= 32'd0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_div_zero  <= 1'b0;
      r_quotient  <= 32'd0;
      r_remainder <= 32'd0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      case (r_state)
        IDLE: begin
          r_busy <= 1'b0;
          if (start) begin
            if (divisor == 32'd0) begin
              r_state    <= DONE;
              r_done     <= 1'b1;
              r_div_zero <= 1'b1;
            end else begin
              r_state <= RUN;
              r_busy  <= 1'b1;
              r_cnt   <= 6'd0;
              r_rem   <= 32'd0;
              r_quo   <= w_abs_a;
              r_dvs   <= w_abs_b;
              r_neg_q <= dividend[31] ^ divisor[31];
              r_neg_r <= dividend[31];
            end
          end
        end
        RUN: begin
          r_rem <= w_fits ? w_diff : w_shift[31:0];
          r_quo <= {r_quo[30:0], w_fits};
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd31) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_quotient  <= r_neg_q ? (~r_quo + 32'd1) : r_quo;
          r_remainder <= r_neg_r ? (~r_rem + 32'd1) : r_rem;
          r_busy      <= 1'b0;
          r_done      <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign div_zero  = r_div_zero;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;

endmodule

// File: tb/tb_signed_div32_seq.sv
// Directed and random bench for signed_div32_seq.
// Expected results are queued when an operation starts and are checked when done pulses.
module tb_signed_div32_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_q = 32'd0;

  always #5 clk = ~clk;

  signed_div32_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .quotient (quotient),
    .remainder(remainder)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, got, exp);
    end
  endtask

  // Reference model built on the language's signed division, which truncates toward zero.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r);
    int sa;
    int sbv;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      sa  = a;
      sbv = b;
      q   = sa / sbv;
      r   = sa % sbv;
    end
  endtask

  task automatic no_done_for(input int cycles, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      seen |= done;
    end
    check(name, {31'd0, seen}, 32'd0);
  endtask

  // Called on a negedge; returns on a negedge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er,
                        input bit repulse, input int reset_at, input string tag);
    exp_t e;
    int   busy_cnt;
    bit   got;
    bit   aborted;
    e.q   = eq;
    e.r   = er;
    e.dz  = (b == 32'd0);
    e.tag = tag;
    sb.push_back(e);

    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;

    busy_cnt = 0;
    got      = 1'b0;
    aborted  = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      if (busy && busy_cnt == 16) check({tag, " hold quotient"}, quotient, last_q);
      if (reset_at >= 0 && busy_cnt == reset_at) begin
        aborted = 1'b1;
        break;
      end
      if (repulse && busy_cnt == 10) begin
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;

    if (aborted) begin
      reset = 1'b0;
      #1;
      check({tag, " rst busy"},      {31'd0, busy},     32'd0);
      check({tag, " rst done"},      {31'd0, done},     32'd0);
      check({tag, " rst div_zero"},  {31'd0, div_zero}, 32'd0);
      check({tag, " rst quotient"},  quotient,          32'd0);
      check({tag, " rst remainder"}, remainder,         32'd0);
      e      = sb.pop_front();
      last_q = 32'd0;
      @(negedge clk);
      reset = 1'b1;
      no_done_for(40, {tag, " no done after abort"});
    end else if (!got) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s timeout: observed no done expected done within 60 cycles", tag);
      e = sb.pop_front();
    end else begin
      e = sb.pop_front();
      check({e.tag, " quotient"},  quotient,          e.q);
      check({e.tag, " remainder"}, remainder,         e.r);
      check({e.tag, " div_zero"},  {31'd0, div_zero}, {31'd0, e.dz});
      check({e.tag, " busy@done"}, {31'd0, busy},     32'd0);
      check({e.tag, " busy cycles"}, busy_cnt, e.dz ? 32'd0 : 32'd33);
      $display("op %s: a=%h b=%h q=%h r=%h dz=%0b busy_cycles=%0d",
               e.tag, a, b, quotient, remainder, div_zero, busy_cnt);
      if (!e.dz) last_q = e.q;
      @(negedge clk);
      check({e.tag, " done pulse width"}, {31'd0, done}, 32'd0);
      if (repulse) no_done_for(40, {tag, " no extra done"});
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] mq;
    logic [31:0] mr;

    reset    = 1'b0;
    start    = 1'b0;
    dividend = 32'd0;
    divisor  = 32'd0;
    #1;
    check("reset busy",      {31'd0, busy},     32'd0);
    check("reset done",      {31'd0, done},     32'd0);
    check("reset div_zero",  {31'd0, div_zero}, 32'd0);
    check("reset quotient",  quotient,          32'd0);
    check("reset remainder", remainder,         32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run_op(32'd100,        32'd7,          32'd14,         32'd2,          1'b0, -1, "100/7");
    run_op(32'd5,          32'd0,          32'd14,         32'd2,          1'b0, -1, "5/0");
    run_op(32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, -1, "-7/2");
    run_op(32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, -1, "7/-2");
    run_op(32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, -1, "min/-1");
    run_op(32'd100,        32'd7,          32'd14,         32'd2,          1'b1, -1, "100/7 repulse");
    run_op(32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 20, "100/7 abort");
    run_op(32'd9,          32'd3,          32'd3,          32'd0,          1'b0, -1, "9/3");
    run_op(32'd1,          32'd0,          32'd3,          32'd0,          1'b0, -1, "1/0");
    run_op(32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          1'b0, -1, "min/1");
    run_op(32'h8000_0000,  32'h8000_0000,  32'd1,          32'd0,          1'b0, -1, "min/min");
    run_op(32'd3,          32'd10,         32'd0,          32'd3,          1'b0, -1, "3/10");

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (rb == 32'd0) rb = 32'd1;
      if ($urandom_range(0, 1) == 1) rb = -rb;
      model(ra, rb, mq, mr);
      run_op(ra, rb, mq, mr, 1'b0, -1, $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
